// File: rtl/button_events.sv
// Turns a debounced push-button level into registered press, release,
// long-press and auto-repeat pulses, with all timing counted in enable ticks.
module button_events #(
  parameter logic ACTIVE_LEVEL     = 1'b1,
  parameter logic RESET_VALUE      = 1'b0,
  parameter int   LONG_PRESS_TICKS = 1000,
  parameter int   REPEAT_TICKS     = 200
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic data_i,
  output logic held_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o,
  output logic repeat_o
);

  localparam int MAX_LR = (LONG_PRESS_TICKS > REPEAT_TICKS) ? LONG_PRESS_TICKS : REPEAT_TICKS;
  localparam int MAX_T  = (MAX_LR > 2) ? MAX_LR : 2;
  localparam int CW     = $clog2(MAX_T);

  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_PRESS_TICKS - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'((REPEAT_TICKS == 0) ? 0 : REPEAT_TICKS - 1);
  localparam bit            REPEAT_ON   = (REPEAT_TICKS != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          prev_q;
  logic          held_q;
  logic          press_q;
  logic          release_q;
  logic          long_q;
  logic          repeat_q;

  logic act;
  logic prev_act;

  assign act      = (data_i == ACTIVE_LEVEL);
  assign prev_act = (prev_q == ACTIVE_LEVEL);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prev_q    <= RESET_VALUE;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      // Pulses always self-clear, even when the following cycle has no tick.
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      if (enable) begin
        prev_q <= data_i;
        case (state_q)
          IDLE: begin
            if (act && !prev_act) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
              press_q <= 1'b1;
              held_q  <= 1'b1;
            end
          end
          PRESSED: begin
            if (!act) begin
              state_q   <= IDLE;
              cnt_q     <= '0;
              release_q <= 1'b1;
              held_q    <= 1'b0;
            end else if (cnt_q == LONG_LAST) begin
              state_q <= LONG;
              cnt_q   <= '0;
              long_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          LONG: begin
            // Release wins over a repeat that would land on the same tick.
            if (!act) begin
              state_q   <= IDLE;
              cnt_q     <= '0;
              release_q <= 1'b1;
              held_q    <= 1'b0;
            end else if (REPEAT_ON && (cnt_q == REPEAT_LAST)) begin
              cnt_q    <= '0;
              repeat_q <= 1'b1;
            end else if (REPEAT_ON) begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign held_o       = held_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_q;
  assign repeat_o     = repeat_q;

endmodule
